// File: rtl/rrf_freelist.sv
// rrf_freelist: circular rename-register allocator, up to two tags per cycle, commit reclaim, mispredict restore
//   clk_i, reset_n_i (async, active low)
//   dp1_req_i/dp2_req_i/stall_dp_i : dispatch requests and stall
//   com_num_i                      : entries retired this cycle
//   prmiss_i/restore_rrf*_i        : pointer restore on misprediction
//   allocatable_o, alloc*_en_o, dst*_rrftag_o : allocation results
//   rrfptr_o/rrfcyc_o/comptr_o/freenum_o      : registered pool state
module rrf_freelist #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               dp1_req_i,
  input  logic               dp2_req_i,
  input  logic               stall_dp_i,
  input  logic [1:0]         com_num_i,
  input  logic               prmiss_i,
  input  logic [RRF_SEL-1:0] restore_rrfptr_i,
  input  logic               restore_rrfcyc_i,
  output logic               allocatable_o,
  output logic               alloc1_en_o,
  output logic               alloc2_en_o,
  output logic [RRF_SEL-1:0] dst1_rrftag_o,
  output logic [RRF_SEL-1:0] dst2_rrftag_o,
  output logic [RRF_SEL-1:0] rrfptr_o,
  output logic               rrfcyc_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic [RRF_SEL:0]   freenum_o
);
  localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);
  logic [RRF_SEL-1:0] rrfptr, comptr, cn;
  logic               rrfcyc, comcyc, cc, fire;
  logic [RRF_SEL:0]   freenum, req_w, com_w, alloc_w, ptr_sum, com_sum, occ, free_nxt;
  logic [1:0]         reqnum;
  assign reqnum        = {1'b0, dp1_req_i} + {1'b0, dp2_req_i};
  assign req_w         = {{(RRF_SEL-1){1'b0}}, reqnum};
  assign com_w         = {{(RRF_SEL-1){1'b0}}, com_num_i};
  assign allocatable_o = freenum >= req_w;
  assign fire          = allocatable_o & ~stall_dp_i & ~prmiss_i & (reqnum != 2'd0);
  assign alloc1_en_o   = fire & dp1_req_i;
  assign alloc2_en_o   = fire & dp2_req_i;
  assign dst1_rrftag_o = rrfptr;
  assign dst2_rrftag_o = rrfptr + {{(RRF_SEL-1){1'b0}}, dp1_req_i};
  assign alloc_w       = fire ? req_w : '0;
  // Extra top bit of each sum is the wrap carry that flips the cycle bit.
  assign ptr_sum       = {1'b0, rrfptr} + alloc_w;
  assign com_sum       = {1'b0, comptr} + com_w;
  assign cn            = com_sum[RRF_SEL-1:0];
  assign cc            = comcyc ^ com_sum[RRF_SEL];
  // Differing cycle bits add RRF_NUM to the pointer distance.
  assign occ           = {restore_rrfcyc_i ^ cc, restore_rrfptr_i} - {1'b0, cn};
  assign free_nxt      = prmiss_i ? FULL - occ : freenum - alloc_w + com_w;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rrfptr  <= '0;
      rrfcyc  <= 1'b0;
      comptr  <= '0;
      comcyc  <= 1'b0;
      freenum <= FULL;
    end else begin
      rrfptr  <= prmiss_i ? restore_rrfptr_i : ptr_sum[RRF_SEL-1:0];
      rrfcyc  <= prmiss_i ? restore_rrfcyc_i : rrfcyc ^ ptr_sum[RRF_SEL];
      comptr  <= cn;
      comcyc  <= cc;
      freenum <= free_nxt;
    end
  assign rrfptr_o  = rrfptr;
  assign rrfcyc_o  = rrfcyc;
  assign comptr_o  = comptr;
  assign freenum_o = freenum;
endmodule

// File: tb/tb_rrf_freelist.sv
// tb_rrf_freelist: directed vectors with queued expectations checked by an independent monitor
module tb_rrf_freelist;
  logic       clk_i = 1'b0, reset_n_i = 1'b0;
  logic       dp1_req_i = 1'b0, dp2_req_i = 1'b0, stall_dp_i = 1'b0, prmiss_i = 1'b0, restore_rrfcyc_i = 1'b0;
  logic [1:0] com_num_i = 2'd0;
  logic [5:0] restore_rrfptr_i = 6'd0;
  logic       allocatable_o, alloc1_en_o, alloc2_en_o, rrfcyc_o;
  logic [5:0] dst1_rrftag_o, dst2_rrftag_o, rrfptr_o, comptr_o;
  logic [6:0] freenum_o;
  int         n_vec = 0, n_bad = 0;
  typedef struct packed {
    logic       a, e1, e2;
    logic [5:0] t1, t2, p;
    logic       c;
    logic [5:0] cp;
    logic [6:0] f;
  } exp_t;
  exp_t q[$];
  rrf_freelist #(.RRF_NUM(64), .RRF_SEL(6)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .dp1_req_i(dp1_req_i), .dp2_req_i(dp2_req_i),
    .stall_dp_i(stall_dp_i), .com_num_i(com_num_i), .prmiss_i(prmiss_i),
    .restore_rrfptr_i(restore_rrfptr_i), .restore_rrfcyc_i(restore_rrfcyc_i),
    .allocatable_o(allocatable_o), .alloc1_en_o(alloc1_en_o), .alloc2_en_o(alloc2_en_o),
    .dst1_rrftag_o(dst1_rrftag_o), .dst2_rrftag_o(dst2_rrftag_o), .rrfptr_o(rrfptr_o),
    .rrfcyc_o(rrfcyc_o), .comptr_o(comptr_o), .freenum_o(freenum_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic ap(input int rst, d1, d2, st, cn, pm, rp, rc, a, e1, e2, t1, t2, p, c, cp, f);
    exp_t e;
    @(posedge clk_i);
    #1;
    reset_n_i        = !rst[0];
    dp1_req_i        = d1[0];
    dp2_req_i        = d2[0];
    stall_dp_i       = st[0];
    com_num_i        = 2'(cn);
    prmiss_i         = pm[0];
    restore_rrfptr_i = 6'(rp);
    restore_rrfcyc_i = rc[0];
    e = '{a[0], e1[0], e2[0], 6'(t1), 6'(t2), 6'(p), c[0], 6'(cp), 7'(f)};
    q.push_back(e);
  endtask
  task automatic idle_chk(input int p, c, cp, f);
    ap(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, p, p, p, c, cp, f);
  endtask
  always @(negedge clk_i) begin
    exp_t e, g;
    if (reset_n_i && (com_num_i == 2'd3 || 32'(com_num_i) > 64 - 32'(freenum_o)))
      $error("illegal commit count %0d with freenum %0d", com_num_i, freenum_o);
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{allocatable_o, alloc1_en_o, alloc2_en_o, dst1_rrftag_o, dst2_rrftag_o,
            rrfptr_o, rrfcyc_o, comptr_o, freenum_o};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL vec%0d got a=%b e1=%b e2=%b t1=%0d t2=%0d ptr=%0d cyc=%b com=%0d free=%0d exp a=%b e1=%b e2=%b t1=%0d t2=%0d ptr=%0d cyc=%b com=%0d free=%0d",
                 n_vec, g.a, g.e1, g.e2, g.t1, g.t2, g.p, g.c, g.cp, g.f,
                 e.a, e.e1, e.e2, e.t1, e.t2, e.p, e.c, e.cp, e.f);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired with %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk_i);
    ap(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64);
    idle_chk(0, 0, 0, 64);
    ap(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 64);
    idle_chk(2, 0, 0, 62);
    ap(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 3, 2, 0, 0, 62);
    ap(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 3, 4, 3, 0, 0, 61);
    ap(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 5, 5, 5, 0, 0, 59);
    ap(0, 1, 1, 1, 2, 0, 0, 0, 1, 0, 0, 6, 7, 6, 0, 0, 58);
    idle_chk(6, 0, 2, 60);
    ap(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64);
    for (int i = 0; i < 5; i++)
      ap(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 2*i, 2*i+1, 2*i, 0, 0, 64-2*i);
    ap(0, 1, 1, 0, 1, 1, 4, 0, 1, 0, 0, 10, 11, 10, 0, 0, 54);
    idle_chk(4, 0, 1, 61);
    ap(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64);
    for (int i = 0; i < 31; i++)
      ap(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 2*i, 2*i+1, 2*i, 0, 0, 64-2*i);
    ap(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 62, 63, 62, 0, 0, 2);
    ap(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 63, 0, 63, 0, 0, 1);
    ap(0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 63, 0, 63, 0, 0, 1);
    ap(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 63, 0, 63, 0, 2, 3);
    idle_chk(1, 1, 2, 1);
    ap(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 2, 1);
    ap(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 1, 1, 2, 1);
    idle_chk(2, 1, 2, 0);
    ap(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 2, 1, 2, 0);
    ap(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 2, 2, 2, 1, 2, 0);
    idle_chk(1, 1, 2, 1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_i);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rrf_freelist.md
Name: rrf_freelist

Overview:
- Allocates rename-register (RRF) entries to destination registers at dispatch, up to two per cycle, from a circular pool of RRF_NUM entries.
- Drives the RRF's allocate-tag inputs and reclaims entries as the commit stage retires them.
- Restores its allocation pointer on branch misprediction.
- Sits directly upstream of the rename register file, between decode/dispatch and the RRF.

Parameters:
- RRF_NUM, 64, number of RRF entries; must be a power of two.
- RRF_SEL, 6, tag width; equals log2(RRF_NUM).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- dp1_req_i  in  1  slot-1 instruction needs a destination entry.
- dp2_req_i  in  1  slot-2 instruction needs a destination entry.
- stall_dp_i  in  1  downstream dispatch stall; blocks allocation.
- com_num_i  in  2  entries retired this cycle (0..2).
- prmiss_i  in  1  misprediction restore strobe.
- restore_rrfptr_i  in  RRF_SEL  allocation pointer to restore.
- restore_rrfcyc_i  in  1  wrap bit paired with the restore pointer.
- allocatable_o  out  1  pool can satisfy the current request.
- alloc1_en_o  out  1  slot-1 allocation fires this cycle.
- alloc2_en_o  out  1  slot-2 allocation fires this cycle.
- dst1_rrftag_o  out  RRF_SEL  tag for slot 1.
- dst2_rrftag_o  out  RRF_SEL  tag for slot 2.
- rrfptr_o  out  RRF_SEL  next allocation pointer (registered).
- rrfcyc_o  out  1  allocation wrap bit (registered).
- comptr_o  out  RRF_SEL  oldest un-retired entry (registered).
- freenum_o  out  RRF_SEL+1  free entry count (registered).

Behaviour:
Reset (asynchronous):
- rrfptr=0, rrfcyc=0, comptr=0, comcyc=0, freenum=RRF_NUM.
- All combinational outputs follow from these values.

Request and firing (combinational):
- reqnum = dp1_req_i + dp2_req_i.
- allocatable_o = (freenum >= reqnum).
- fire = allocatable_o & ~stall_dp_i & ~prmiss_i & (reqnum != 0).
- Requests are all-or-nothing. If only one entry is free and both slots request, nothing fires.

Tag assignment:
- dst1_rrftag_o = rrfptr.
- dst2_rrftag_o = rrfptr + dp1_req_i, mod RRF_NUM. If slot 1 has no request, slot 2 receives rrfptr.
- alloc1_en_o = fire & dp1_req_i.
- alloc2_en_o = fire & dp2_req_i.
- Tags are valid whenever the matching enable is high. They also stay driven combinationally when the enable is low.

Normal update (clock edge, no prmiss_i):
- rrfptr += reqnum when fire is high. rrfcyc toggles when the addition wraps past RRF_NUM-1.
- comptr += com_num_i. comcyc toggles on wrap.
- freenum = freenum - (fire ? reqnum : 0) + com_num_i.
- Allocation and commit in the same cycle both apply. An entry retired this cycle is not allocatable until the next cycle.

Misprediction restore (prmiss_i=1, takes priority over allocation):
- rrfptr <= restore_rrfptr_i; rrfcyc <= restore_rrfcyc_i.
- No allocation fires. Commit in the same cycle still advances comptr.
- Let cn be the post-commit comptr and cc the post-commit comcyc.
- occ = restore_rrfptr_i - cn if restore_rrfcyc_i == cc, otherwise RRF_NUM + restore_rrfptr_i - cn.
- freenum <= RRF_NUM - occ.

Boundary conditions:
- Full pool (freenum=0): allocatable_o=1 only when reqnum=0.
- Empty pool (freenum=RRF_NUM): rrfptr==comptr with rrfcyc==comcyc.
- Full pool: rrfptr==comptr with the cycle bits differing.
- Illegal: com_num_i > RRF_NUM - freenum, or com_num_i=3. The bench asserts on these; RRF behaviour is undefined.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Test Plan:
- Reset then dp1=dp2=1, stall=0 -> alloc1/2_en=1, tags 0 and 1; next cycle rrfptr=2, freenum=62.
- Only dp2_req=1 with rrfptr=5 -> dst2_rrftag_o=5, alloc1_en=0; next rrfptr=6, freenum decreases by 1.
- Allocate 63 entries, then dp1=dp2=1 -> allocatable_o=0, no enables, freenum stays 1; add com_num=2 -> next cycle freenum=3 and the dual request fires.
- rrfptr=63, dual request -> tags 63 and 0; next rrfptr=1, rrfcyc=1.
- 10 allocated, comptr=0, prmiss with restore ptr=4, cyc=0, com_num=1 -> rrfptr=4, comptr=1, freenum=61, no enables that cycle.
- stall_dp_i=1 with a dual request and com_num=2 -> no enables; freenum increases by 2, rrfptr unchanged.
